iic_cfg_seq: RTL

//  Sensor/codec register-init sequencer that sits directly upstream of the I2C byte driver.

---
 rtl/iic_cfg_seq_if.sv | 21 ++
 rtl/iic_cfg_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/iic_cfg_seq_if.sv
// Byte-driver handshake between the register-init sequencer and the I2C engine.
// The sequencer is the master; the I2C byte driver is the slave.
interface iic_cfg_seq_if;
    logic        iic_exe;
    logic        iic_rw_ctrl;
    logic        bit_ctrl;
    logic [15:0] iic_addr;
    logic [7:0]  iic_data_in;
    logic        iic_ack;
    logic        iic_done;

    modport master (
        output iic_exe, iic_rw_ctrl, bit_ctrl, iic_addr, iic_data_in,
        input  iic_ack, iic_done
    );

    modport slave (
        input  iic_exe, iic_rw_ctrl, bit_ctrl, iic_addr, iic_data_in,
        output iic_ack, iic_done
    );
endinterface

// File: rtl/iic_cfg_seq.sv
// Power-up register-init sequencer: walks a ROM table of {reg_addr, reg_data} entries,
// issues one I2C write per entry, retries missing ACKs and reports done/error status.
module iic_cfg_seq #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned REG_NUM    = 200,
    parameter logic [19:0] INIT_DELAY = 20'd1000000,
    parameter logic [1:0]  MAX_RETRY  = 2'd3,
    parameter bit          ADDR16     = 1'b1,
    parameter logic [19:0] TIMEOUT    = 20'd500000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    iic_cfg_seq_if.master     iic,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] err_index
);

    typedef enum logic [2:0] {
        PWR_WAIT, FETCH, LATCH, ISSUE, WAIT, CHECK, DONE, ERROR
    } state_t;

    localparam logic [2:0]        ACK_EXP  = ADDR16 ? 3'd4 : 3'd3;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(REG_NUM - 1);

    state_t            state, state_nx;
    logic [19:0]       dly_cnt;
    logic [19:0]       tmo_cnt;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        retry_cnt;
    logic [2:0]        ack_cnt;
    logic              done_d, ack_d;
    logic              exe_q;
    logic [15:0]       addr_q;
    logic [7:0]        data_q;

    logic done_rise, ack_rise, ack_ok;
    assign done_rise = iic.iic_done & ~done_d;
    assign ack_rise  = iic.iic_ack & ~ack_d;
    assign ack_ok    = (ack_cnt == ACK_EXP);

    assign rom_addr        = idx;
    assign iic.iic_exe     = exe_q;
    assign iic.iic_addr    = addr_q;
    assign iic.iic_data_in = data_q;
    assign iic.iic_rw_ctrl = 1'b1;
    assign iic.bit_ctrl    = ADDR16;

    always_comb begin
        state_nx = state;
        case (state)
            PWR_WAIT: if (dly_cnt == INIT_DELAY - 20'd1) state_nx = FETCH;
            FETCH:    state_nx = LATCH;
            LATCH:    state_nx = ISSUE;
            ISSUE:    state_nx = WAIT;
            WAIT: begin
                // A completed transfer wins over a timeout landing on the same cycle.
                if (done_rise)                          state_nx = CHECK;
                else if (tmo_cnt == TIMEOUT - 20'd1)    state_nx = ERROR;
            end
            CHECK: begin
                if (ack_ok)                      state_nx = (idx == IDX_LAST) ? DONE : FETCH;
                else if (retry_cnt < MAX_RETRY)  state_nx = ISSUE;
                else                             state_nx = ERROR;
            end
            DONE, ERROR: if (start) state_nx = FETCH;
            default:  state_nx = PWR_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state     <= PWR_WAIT;
            dly_cnt   <= '0;
            tmo_cnt   <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            ack_cnt   <= '0;
            done_d    <= 1'b0;
            ack_d     <= 1'b0;
            exe_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= '0;
        end else begin
            state  <= state_nx;
            done_d <= iic.iic_done;
            ack_d  <= iic.iic_ack;
            case (state)
                PWR_WAIT: dly_cnt <= dly_cnt + 20'd1;
                LATCH: begin
                    {addr_q, data_q} <= rom_data;
                    retry_cnt        <= '0;
                end
                ISSUE: begin
                    ack_cnt <= '0;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (ack_rise && ack_cnt != 3'd7) ack_cnt <= ack_cnt + 3'd1;
                    tmo_cnt <= tmo_cnt + 20'd1;
                end
                CHECK: begin
                    if (ack_ok && idx != IDX_LAST)             idx <= idx + ADDR_W'(1);
                    else if (!ack_ok && retry_cnt < MAX_RETRY) retry_cnt <= retry_cnt + 2'd1;
                end
                DONE, ERROR: if (start) idx <= '0;
                default: ;
            endcase
            // Outputs are registered from the next state so they line up with the state they describe.
            exe_q     <= (state_nx == ISSUE) || (state_nx == WAIT);
            cfg_busy  <= (state_nx != DONE) && (state_nx != ERROR);
            cfg_done  <= (state_nx == DONE);
            cfg_err   <= (state_nx == ERROR);
            err_index <= (state_nx == ERROR) ? idx : '0;
        end
    end

endmodule
